// File: rtl/unit_a_ctrl.sv
// -----------------------------------------------------------------------------
// unit_a_ctrl
//
// Control sequencer for one convolution unit. For every (depth, filter) pass it
// reads one KxK kernel from weight memory into the weight FIFO, then streams
// the IFM tile into the IFM FIFO. It pulses conv_enable once for each complete
// output window.
//
// Ports
//   clk             clock
//   reset           synchronous, active-high reset
//   start           begin a layer (only sampled in IDLE)
//   ifm_valid       upstream pixel valid this cycle
//   wm_enable_read  weight-memory read strobe
//   wm_address      weight-memory read address
//   wm_fifo_enable  push weight-memory data (1-cycle read latency) into weight FIFO
//   fifo_enable     push upstream pixel into IFM FIFO / pixel accept to upstream
//   conv_enable     convolution core computes the current window
//   busy            layer in progress
//   done            one-cycle pulse after the last pass
// -----------------------------------------------------------------------------
module unit_a_ctrl #(
    parameter int IFM_SIZE          = 5,
    parameter int KERNAL_SIZE       = 5,
    parameter int NUMBER_OF_FILTERS = 160,
    parameter int CEIL_DEPTH        = 8,
    parameter int ADDRESS_SIZE_WM   = $clog2(KERNAL_SIZE*KERNAL_SIZE*NUMBER_OF_FILTERS*CEIL_DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       ifm_valid,
    output logic                       wm_enable_read,
    output logic [ADDRESS_SIZE_WM-1:0] wm_address,
    output logic                       wm_fifo_enable,
    output logic                       fifo_enable,
    output logic                       conv_enable,
    output logic                       busy,
    output logic                       done
);

    localparam int TAPS  = KERNAL_SIZE * KERNAL_SIZE;
    localparam int TAP_W = (TAPS > 1)              ? $clog2(TAPS)              : 1;
    localparam int PIX_W = (IFM_SIZE > 1)          ? $clog2(IFM_SIZE)          : 1;
    localparam int F_W   = (NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1;
    localparam int D_W   = (CEIL_DEPTH > 1)        ? $clog2(CEIL_DEPTH)        : 1;

    localparam logic [TAP_W-1:0]           TAP_LAST  = TAP_W'(TAPS - 1);
    localparam logic [TAP_W-1:0]           TAP_ONE   = TAP_W'(1);
    localparam logic [PIX_W-1:0]           PIX_LAST  = PIX_W'(IFM_SIZE - 1);
    localparam logic [PIX_W-1:0]           PIX_KM1   = PIX_W'(KERNAL_SIZE - 1);
    localparam logic [PIX_W-1:0]           PIX_ONE   = PIX_W'(1);
    localparam logic [F_W-1:0]             F_LAST    = F_W'(NUMBER_OF_FILTERS - 1);
    localparam logic [F_W-1:0]             F_ONE     = F_W'(1);
    localparam logic [D_W-1:0]             D_LAST    = D_W'(CEIL_DEPTH - 1);
    localparam logic [D_W-1:0]             D_ONE     = D_W'(1);
    localparam logic [ADDRESS_SIZE_WM-1:0] ADDR_STEP = ADDRESS_SIZE_WM'(1);

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DONE} state_t;

    state_t                     r_state;
    logic [TAP_W-1:0]           r_tap;
    logic [PIX_W-1:0]           r_row;
    logic [PIX_W-1:0]           r_col;
    logic [F_W-1:0]             r_filter;
    logic [D_W-1:0]             r_depth;
    // Next address to issue; the walk is depth-major, filter-minor, tap-minor,
    // which is exactly one running count, so no multiplier is needed.
    logic [ADDRESS_SIZE_WM-1:0] r_rd_ptr;
    logic [ADDRESS_SIZE_WM-1:0] r_wm_address;
    logic                       r_wm_enable_read;
    logic                       r_wm_fifo_enable;
    logic                       r_conv_enable;
    logic                       r_busy;
    logic                       r_done;
    // One extra STREAM cycle after the final pixel of the final pass, so that
    // done lands after the trailing conv_enable rather than on top of it.
    logic                       r_drain;

    logic w_push;
    logic w_window;
    logic w_pass_end;
    logic w_last_pass;

    // Pixel accept is a combinational pass-through of ifm_valid, gated by state.
    assign w_push      = (r_state == STREAM) && !r_drain && ifm_valid;
    assign w_window    = w_push && (r_row >= PIX_KM1) && (r_col >= PIX_KM1);
    assign w_pass_end  = w_push && (r_row == PIX_LAST) && (r_col == PIX_LAST);
    assign w_last_pass = (r_filter == F_LAST) && (r_depth == D_LAST);

    // NOTE: every register below is written with <= so all updates in a cycle
    // see the pre-edge values; mixing in = would make results order-dependent.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_tap            <= '0;
            r_row            <= '0;
            r_col            <= '0;
            r_filter         <= '0;
            r_depth          <= '0;
            r_rd_ptr         <= '0;
            r_wm_address     <= '0;
            r_wm_enable_read <= 1'b0;
            r_wm_fifo_enable <= 1'b0;
            r_conv_enable    <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_drain          <= 1'b0;
        end else begin
            // Weight memory answers one cycle after the read strobe.
            r_wm_fifo_enable <= r_wm_enable_read;
            r_conv_enable    <= w_window;
            r_done           <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state          <= LOAD_W;
                        r_busy           <= 1'b1;
                        r_wm_enable_read <= 1'b1;
                        r_wm_address     <= r_rd_ptr;
                        r_rd_ptr         <= r_rd_ptr + ADDR_STEP;
                        r_tap            <= '0;
                    end
                end

                LOAD_W: begin
                    if (r_tap == TAP_LAST) begin
                        r_state          <= STREAM;
                        r_wm_enable_read <= 1'b0;
                        r_row            <= '0;
                        r_col            <= '0;
                    end else begin
                        r_tap        <= r_tap + TAP_ONE;
                        r_wm_address <= r_rd_ptr;
                        r_rd_ptr     <= r_rd_ptr + ADDR_STEP;
                    end
                end

                STREAM: begin
                    if (r_drain) begin
                        r_drain <= 1'b0;
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_push) begin
                        if (r_col == PIX_LAST) begin
                            r_col <= '0;
                            r_row <= (r_row == PIX_LAST) ? '0 : r_row + PIX_ONE;
                        end else begin
                            r_col <= r_col + PIX_ONE;
                        end

                        if (w_pass_end) begin
                            if (w_last_pass) begin
                                r_drain      <= 1'b1;
                                r_filter     <= '0;
                                r_depth      <= '0;
                                r_rd_ptr     <= '0;
                                r_wm_address <= '0;
                            end else begin
                                if (r_filter == F_LAST) begin
                                    r_filter <= '0;
                                    r_depth  <= r_depth + D_ONE;
                                end else begin
                                    r_filter <= r_filter + F_ONE;
                                end
                                // First read of the next kernel overlaps the
                                // trailing conv_enable of this pass.
                                r_state          <= LOAD_W;
                                r_wm_enable_read <= 1'b1;
                                r_wm_address     <= r_rd_ptr;
                                r_rd_ptr         <= r_rd_ptr + ADDR_STEP;
                                r_tap            <= '0;
                            end
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wm_enable_read = r_wm_enable_read;
    assign wm_address     = r_wm_address;
    assign wm_fifo_enable = r_wm_fifo_enable;
    assign fifo_enable    = w_push;
    assign conv_enable    = r_conv_enable;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule

// File: tb/tb_unit_a_ctrl.sv
// -----------------------------------------------------------------------------
// tb_unit_a_ctrl
//
// Directed bench for unit_a_ctrl. One instance uses IFM_SIZE=3, K=2, NF=2,
// CEIL_DEPTH=2; a second uses IFM_SIZE=K=5, NF=1, CEIL_DEPTH=1. Inputs are
// driven on the falling edge and outputs sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_unit_a_ctrl;

    localparam int IFM_SIZE = 3;
    localparam int K        = 2;
    localparam int NF       = 2;
    localparam int DEPTH    = 2;
    localparam int AW       = $clog2(K*K*NF*DEPTH);
    localparam int AW6      = $clog2(25);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          ifm_valid = 1'b0;
    logic          wm_enable_read;
    logic [AW-1:0] wm_address;
    logic          wm_fifo_enable;
    logic          fifo_enable;
    logic          conv_enable;
    logic          busy;
    logic          done;

    logic           start6 = 1'b0;
    logic           ifm_valid6 = 1'b0;
    logic           wm_enable_read6;
    logic [AW6-1:0] wm_address6;
    logic           wm_fifo_enable6;
    logic           fifo_enable6;
    logic           conv_enable6;
    logic           busy6;
    logic           done6;

    unit_a_ctrl #(
        .IFM_SIZE(IFM_SIZE), .KERNAL_SIZE(K), .NUMBER_OF_FILTERS(NF), .CEIL_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .ifm_valid(ifm_valid),
        .wm_enable_read(wm_enable_read), .wm_address(wm_address),
        .wm_fifo_enable(wm_fifo_enable), .fifo_enable(fifo_enable),
        .conv_enable(conv_enable), .busy(busy), .done(done)
    );

    unit_a_ctrl #(
        .IFM_SIZE(5), .KERNAL_SIZE(5), .NUMBER_OF_FILTERS(1), .CEIL_DEPTH(1)
    ) dut6 (
        .clk(clk), .reset(reset), .start(start6), .ifm_valid(ifm_valid6),
        .wm_enable_read(wm_enable_read6), .wm_address(wm_address6),
        .wm_fifo_enable(wm_fifo_enable6), .fifo_enable(fifo_enable6),
        .conv_enable(conv_enable6), .busy(busy6), .done(done6)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    // Results gathered by run_layer.
    int            r_reads, r_push, r_conv, r_done, r_addr_err, r_fe_err, r_overlap;
    int            r_last_conv, r_done_cyc;
    logic          r_done_busy, r_post_busy, r_post_rd, r_post2_rd;
    logic [AW-1:0] r_post_addr, r_post2_addr, t_addr14;
    logic [14:0]   t_rd, t_wfe, t_fe, t_ce, t_busy;

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        start     = 1'b0;
        ifm_valid = 1'b0;
        start6    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Start pulse at relative cycle 0, run until done plus two cycles.
    task automatic run_layer(input bit toggle_valid, input bit hold_start);
        int  exp_addr;
        int  after;
        bit  seen_done;
        exp_addr = 0; after = 0; seen_done = 1'b0;
        r_reads = 0; r_push = 0; r_conv = 0; r_done = 0; r_addr_err = 0;
        r_fe_err = 0; r_overlap = 0; r_last_conv = -1; r_done_cyc = -1;
        r_done_busy = 1'b1; r_post_busy = 1'b1; r_post_rd = 1'b1; r_post2_rd = 1'b0;
        r_post_addr = '1; r_post2_addr = '1; t_addr14 = '1;
        t_rd = '0; t_wfe = '0; t_fe = '0; t_ce = '0; t_busy = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            start     = hold_start || (cyc == 0);
            ifm_valid = toggle_valid ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (cyc < 15) begin
                t_rd[cyc[3:0]]   = wm_enable_read;
                t_wfe[cyc[3:0]]  = wm_fifo_enable;
                t_fe[cyc[3:0]]   = fifo_enable;
                t_ce[cyc[3:0]]   = conv_enable;
                t_busy[cyc[3:0]] = busy;
                if (cyc == 14) t_addr14 = wm_address;
            end
            if (!seen_done) begin
                if (wm_enable_read) begin
                    r_reads++;
                    if (wm_address != AW'(exp_addr)) r_addr_err++;
                    exp_addr++;
                end
                if (fifo_enable) r_push++;
                if (fifo_enable && !ifm_valid) r_fe_err++;
                if (fifo_enable && wm_enable_read) r_overlap++;
                if (conv_enable) begin
                    r_conv++;
                    r_last_conv = cyc;
                end
                if (done) begin
                    seen_done   = 1'b1;
                    r_done++;
                    r_done_cyc  = cyc;
                    r_done_busy = busy;
                end
            end else begin
                after++;
                if (done) r_done++;
                if (after == 1) begin
                    r_post_addr = wm_address;
                    r_post_busy = busy;
                    r_post_rd   = wm_enable_read;
                end else begin
                    r_post2_rd   = wm_enable_read;
                    r_post2_addr = wm_address;
                    break;
                end
            end
        end
        start     = 1'b0;
        ifm_valid = 1'b0;
    endtask

    initial begin
        int reads6, push6, conv6, done6_n, last_push6, conv6_cyc, done_seen5;

        // Reset state.
        do_reset();
        #1;
        check("reset_outputs", {wm_enable_read, wm_address, wm_fifo_enable, fifo_enable,
                                conv_enable, busy, done}, 0);
        @(negedge clk);
        ifm_valid = 1'b1;
        #1;
        check("idle_no_push", {fifo_enable, wm_enable_read, busy}, 0);

        // Scenarios 1 and 2: full layer, no stalls.
        run_layer(1'b0, 1'b0);
        check("s1_rd_trace",   t_rd,   32'h401E);
        check("s1_wfe_trace",  t_wfe,  32'h003C);
        check("s1_fe_trace",   t_fe,   32'h3FE0);
        check("s1_ce_trace",   t_ce,   32'h6C00);
        check("s1_busy_trace", t_busy, 32'h7FFE);
        check("s1_addr_c14",   t_addr14, 4);
        check("s2_reads",      r_reads, 16);
        check("s2_addr_order", r_addr_err, 0);
        check("s2_pushes",     r_push, 36);
        check("s2_convs",      r_conv, 16);
        check("s2_done_count", r_done, 1);
        check("s2_done_cycle", r_done_cyc, 54);
        check("s2_done_after_conv", r_done_cyc - r_last_conv, 1);
        check("s2_busy_at_done", r_done_busy, 0);
        check("s2_addr_after", r_post_addr, 0);
        check("s2_idle_after", {r_post_busy, r_post_rd, r_post2_rd}, 0);

        // Scenario 3: ifm_valid toggling.
        do_reset();
        run_layer(1'b1, 1'b0);
        check("s3_fe_mirror",  r_fe_err, 0);
        check("s3_no_overlap", r_overlap, 0);
        check("s3_pushes",     r_push, 36);
        check("s3_convs",      r_conv, 16);
        check("s3_reads",      r_reads, 16);
        check("s3_done_count", r_done, 1);

        // Scenario 4: start held high.
        do_reset();
        run_layer(1'b0, 1'b1);
        check("s4_reads",        r_reads, 16);
        check("s4_done_count",   r_done, 1);
        check("s4_done_cycle",   r_done_cyc, 54);
        check("s4_idle_gap",     {r_post_busy, r_post_rd}, 0);
        check("s4_restart_rd",   r_post2_rd, 1);
        check("s4_restart_addr", r_post2_addr, 0);

        // Scenario 5: reset at 3rd LOAD_W cycle of pass 2 (cycle 16).
        do_reset();
        for (int cyc = 0; cyc < 17; cyc++) begin
            @(negedge clk);
            start     = (cyc == 0);
            ifm_valid = 1'b1;
            #1;
            if (cyc == 16) begin
                check("s5_pre_reset", {wm_enable_read, wm_address}, {1'b1, 4'd6});
                reset = 1'b1;
            end
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        #1;
        check("s5_outputs_after_reset", {wm_enable_read, wm_address, wm_fifo_enable,
                                         fifo_enable, conv_enable, busy, done}, 0);
        done_seen5 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (done || busy) done_seen5++;
        end
        check("s5_stays_idle", done_seen5, 0);
        run_layer(1'b0, 1'b0);
        check("s5_restart_reads", r_reads, 16);
        check("s5_restart_order", r_addr_err, 0);
        check("s5_restart_done",  r_done, 1);

        // Scenario 6: IFM_SIZE == K degenerate case on the second instance.
        do_reset();
        reads6 = 0; push6 = 0; conv6 = 0; done6_n = 0; last_push6 = -1; conv6_cyc = -1;
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(negedge clk);
            start6     = (cyc == 0);
            ifm_valid6 = 1'b1;
            #1;
            if (wm_enable_read6) reads6++;
            if (fifo_enable6) begin
                push6++;
                last_push6 = cyc;
            end
            if (conv_enable6) begin
                conv6++;
                conv6_cyc = cyc;
            end
            if (done6) begin
                done6_n++;
                break;
            end
        end
        start6     = 1'b0;
        ifm_valid6 = 1'b0;
        check("s6_reads",      reads6, 25);
        check("s6_pushes",     push6, 25);
        check("s6_convs",      conv6, 1);
        check("s6_conv_cycle", conv6_cyc, 51);
        check("s6_conv_after_push", conv6_cyc - last_push6, 1);
        check("s6_done",       done6_n, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/unit_a_ctrl.md
Name: unit_a_ctrl

Overview:
- Sequencer that drives the control side of one convolution unit (weight memory, 25-tap weight FIFO, IFM line FIFO, convolution core). It is the initiator on that interface.
- For every depth slice and every filter, it reads one KxK kernel from weight memory into the weight FIFO, then streams the full IFM tile through the IFM FIFO. It pulses conv_enable once per valid output window.
- One instance sits beside each unit in the layer datapath.

Parameters:
- IFM_SIZE, 5, IFM tile width/height in pixels.
- KERNAL_SIZE, 5, kernel width/height.
- NUMBER_OF_FILTERS, 160, filters per layer.
- CEIL_DEPTH, 8, depth slices handled by this unit.
- ADDRESS_SIZE_WM, $clog2(KERNAL_SIZE*KERNAL_SIZE*NUMBER_OF_FILTERS*CEIL_DEPTH), weight-memory address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin layer; sampled only in IDLE.
- ifm_valid  in  1  upstream pixel on unit_data_in is valid this cycle.
- wm_enable_read  out  1  weight-memory read strobe.
- wm_address  out  ADDRESS_SIZE_WM  weight-memory read address.
- wm_fifo_enable  out  1  push weight-memory output into the weight FIFO.
- fifo_enable  out  1  push unit_data_in into the IFM FIFO; also acts as the pixel-accept to upstream.
- conv_enable  out  1  convolution core computes the current window.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last pass.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, and every output is 0, including wm_address. All counters are 0.
- Reset has priority in every state. Reset mid-operation aborts the layer immediately, with no done pulse. Any FIFO contents are don't-care.
- States: IDLE, LOAD_W, STREAM, DONE.
- IDLE:
  - start=1 moves to LOAD_W on the next cycle and sets busy=1.
  - start=0 stays in IDLE.
  - start while not in IDLE is ignored.
- LOAD_W:
  - Lasts exactly KERNAL_SIZE^2 cycles.
  - Each cycle: wm_enable_read=1 and wm_address=current read pointer; the pointer then increments by 1.
  - After the last read, go to STREAM.
- Read pointer:
  - Single running counter; no multiplier.
  - Address order is depth-major, filter-minor, tap-minor: addr = (d*NUMBER_OF_FILTERS + f)*K*K + tap.
  - Resets to 0 at layer end.
- Weight FIFO push:
  - Memory read latency is 1 cycle, so wm_fifo_enable equals wm_enable_read delayed 1 cycle.
  - The last weight push therefore falls in the first STREAM cycle. That is legal.
- STREAM:
  - fifo_enable = ifm_valid (combinational pass-through, gated by state).
  - The pixel counter (row r, col c, raster order) advances only on fifo_enable=1.
  - ifm_valid=0 stalls with no push and no counter change. Stall length is unbounded.
- conv_enable:
  - Registered. Asserted for 1 cycle in the cycle after a push of pixel (r,c) with r>=K-1 and c>=K-1.
  - This gives (IFM_SIZE-K+1)^2 pulses per pass.
- End of pass: after the push of pixel (IFM_SIZE-1, IFM_SIZE-1):
  - If (f,d) is not the last pass: f increments, wrapping to 0 and incrementing d. Go to LOAD_W.
  - Otherwise go to DONE.
- Back-to-back pass: the first LOAD_W read of the next pass coincides with the trailing conv_enable of the previous pass. That is legal.
- DONE: lasts 1 cycle with done=1, busy=0. Then IDLE. busy is low in IDLE and DONE.
- Outputs outside their states:
  - wm_enable_read=0 outside LOAD_W.
  - fifo_enable=0 outside STREAM.
  - wm_address holds its last value outside LOAD_W, except at layer end, where it returns to 0.
- Per-pass cycle count with no stalls: K^2 + IFM_SIZE^2.
- Total per layer:
  - NUMBER_OF_FILTERS*CEIL_DEPTH passes.
  - K^2*NUMBER_OF_FILTERS*CEIL_DEPTH reads.
  - NUMBER_OF_FILTERS*CEIL_DEPTH*(IFM_SIZE-K+1)^2 conv_enable pulses.
- Degenerate case IFM_SIZE==K: exactly one conv_enable per pass, following the last pixel.

Test Plan:
- Bench parameters for scenarios 1–5: IFM_SIZE=3, K=2, NF=2, CEIL_DEPTH=2.
1. Reset then start pulse at cycle 0, ifm_valid held 1 -> LOAD_W in cycles 1–4 with wm_address 0,1,2,3; wm_fifo_enable high in cycles 2–5; STREAM in cycles 5–13; conv_enable high in cycles 10,11,13,14; next LOAD_W at cycle 14 with addr 4.
2. Full layer, no stalls -> exactly 16 reads (addresses 0..15, each once, ascending), 36 fifo_enable pulses, 16 conv_enable pulses; done pulses once, in the cycle after the final conv_enable; wm_address=0 afterwards.
3. ifm_valid toggled 1,0,1,0… in STREAM -> fifo_enable mirrors ifm_valid; conv_enable count still 16; no pixel is skipped or double-counted.
4. start held high for the entire layer -> one layer only; start is re-accepted in the IDLE cycle after DONE.
5. reset asserted at the 3rd LOAD_W cycle of pass 2 -> next cycle: IDLE, all outputs 0, no done; a new start begins again at address 0.
6. IFM_SIZE=K=5, NF=1, CEIL_DEPTH=1 -> 25 reads, 25 pushes, exactly one conv_enable, in the cycle after the 25th push.
